alu16_nibble_seq: RTL
=====================

Name: alu16_nibble_seq

Overview:
Sequential 16-bit ALU controller that sits directly upstream of the existing 4-bit sum/carry slice (the R stage). It feeds that stage, consumes what it produces, and accumulates the results.
- Per cycle, one operand nibble is converted into the slice's p/g inputs (the 74181-style L-stage function).
- The active-low carry is rippled between nibbles through a register.
- The full word result, carry-out and A=B flag are assembled after NIBBLES cycles.
- The block uses one physical slice instead of four, so datapath area is traded for latency.

Parameters:
NIBBLES, 4, number of 4-bit slices per word; word width W = 4*NIBBLES.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  request; sampled only in IDLE (or DONE).
a  in  W  operand A.
b  in  W  operand B.
s  in  4  function select S[3:0], 74181 active-high table.
m  in  1  mode; 1 = logic, 0 = arithmetic.
ci_n  in  1  carry-in, active-low (0 = carry).
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse when results are valid.
y  out  W  result word.
co_n  out  1  final carry-out, active-low.
aeqb  out  1  A=B flag: AND of all slice aeqb outputs.
slice_p  out  4  propagate nibble to slice.
slice_g  out  4  generate nibble to slice.
slice_m  out  1  mode to slice.
slice_ci_n  out  1  carry-in to slice.
slice_y  in  4  slice sum nibble.
slice_co_n  in  1  slice carry-out, active-low.
slice_aeqb  in  1  slice A=B output.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-run):
  - state returns to IDLE;
  - busy=0, done=0, y=0, co_n=1, aeqb=0;
  - operand registers and nibble index cleared.
- States:
  - IDLE: start=1 latches a, b, s, m; carry_n<=ci_n; idx<=0; aeqb_acc<=1; y<=0; go to RUN.
  - RUN:
    - busy=1.
    - Each cycle, nibble idx is driven combinationally from registers: for bit i of nibble idx, slice_p[i] = ~(A | B&S0 | ~B&S1) and slice_g[i] = ~(A&~B&S2 | A&B&S3), with A, B the latched bits.
    - slice_m = latched m; slice_ci_n = carry_n.
    - At the edge: y[4*idx+3:4*idx] <= slice_y; carry_n <= slice_co_n; aeqb_acc <= aeqb_acc & slice_aeqb; idx <= idx+1.
    - When idx = NIBBLES-1, go to DONE.
  - DONE:
    - done=1 for exactly this cycle; busy=0.
    - co_n = carry_n; aeqb = aeqb_acc.
    - Next state is IDLE, or RUN directly if start=1 (new operands latched, same as the IDLE rule).
- Outputs:
  - In IDLE and DONE, the slice is driven idle: slice_p=4'hF, slice_g=4'hF, slice_ci_n=1, slice_m=1.
  - y, co_n and aeqb become valid in the DONE cycle and hold until the next start is accepted or reset.
  - In RUN, y shows partial content; it is not valid.
- Latency: start accepted at edge 0; done high during the cycle after edge NIBBLES (NIBBLES+1 cycles start-to-done). Back-to-back throughput is one operation per NIBBLES+1 cycles.
- Boundary rules:
  - start while in RUN is ignored; latched operands are unchanged.
  - Carry ripple:
    - Logic mode (m=1): carry_n still updates from slice_co_n.
    - co_n is meaningful only when m=0.
  - The idx counter needs ceil(log2(NIBBLES)) bits; no wrap occurs in RUN, because the exit happens at NIBBLES-1.
  - a, b, s, m and ci_n may change freely after start is accepted.
  - rst has priority over start in the same cycle.

Test Plan:
- Add: a=0x1234, b=0x4321, s=1001, m=0, ci_n=1, one start pulse -> busy for 4 cycles, done pulse in 5th cycle; y=0x5555, co_n=1.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, s=1001, m=0, ci_n=1 -> y=0x0000, co_n=0.
- Subtract and A=B:
  - a=0x5000, b=0x1000, s=0110, m=0, ci_n=0 -> y=0x4000, co_n=0.
  - a=b=0x3C3C, s=0110, m=0, ci_n=1 -> y=0xFFFF, aeqb=1.
- Logic XOR: a=0xF0F0, b=0xFF00, s=0110, m=1 -> y=0x0FF0, aeqb=0; slice_m=1 in every RUN cycle.
- Control hazards:
  - start re-asserted with a=0x0000 during RUN of the add test -> ignored; y=0x5555 still.
  - Start held high at DONE -> new run starts with no idle cycle.
- Reset mid-run: rst=1 at 2nd RUN cycle -> next cycle busy=0, done=0, y=0, co_n=1, aeqb=0; no done pulse follows; a subsequent start runs normally.

Source files
------------

// File: rtl/alu16_nibble_seq.sv
// Nibble-serial 74181-style ALU controller: computes one nibble of the L-stage p/g per cycle
// and drives an external 4-bit sum/carry slice. It ripples the carry and assembles the word.
module alu16_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   ci_n,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   y,
  output logic                   co_n,
  output logic                   aeqb,
  output logic [3:0]             slice_p,
  output logic [3:0]             slice_g,
  output logic                   slice_m,
  output logic                   slice_ci_n,
  input  logic [3:0]             slice_y,
  input  logic                   slice_co_n,
  input  logic                   slice_aeqb
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [3:0]      s_reg;
  logic            m_reg;
  logic            carry_n_reg;
  logic [IW-1:0]   idx_reg;
  logic            aeqb_acc_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            co_n_reg;
  logic            aeqb_reg;

  logic            running;
  logic            accept;
  logic            last_nibble;
  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [3:0]      cur_a;
  logic [3:0]      cur_b;
  logic [3:0]      p_bits;
  logic [3:0]      g_bits;

  assign running     = (state_reg == RUN);
  // A new request is taken in IDLE and also in DONE, which gives back-to-back operation.
  assign accept      = start && (state_reg != RUN);
  assign last_nibble = (idx_reg == IW'(NIBBLES - 1));

  // Split the latched operands into nibbles and keep one result register per nibble.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibble
    logic [3:0] nib_reg;

    assign a_nib[gi] = a_reg[4*gi +: 4];
    assign b_nib[gi] = b_reg[4*gi +: 4];

    always_ff @(posedge clk) begin
      if (rst || accept) begin
        nib_reg <= 4'h0;
      end else if (running && (idx_reg == IW'(gi))) begin
        nib_reg <= slice_y;
      end
    end

    assign y[4*gi +: 4] = nib_reg;
  end

  assign cur_a = a_nib[idx_reg];
  assign cur_b = b_nib[idx_reg];

  // L-stage: active-low propagate and generate terms of the selected nibble.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lstage
    assign p_bits[gi] = ~(cur_a[gi] | (cur_b[gi] & s_reg[0]) | (~cur_b[gi] & s_reg[1]));
    assign g_bits[gi] = ~((cur_a[gi] & ~cur_b[gi] & s_reg[2]) | (cur_a[gi] & cur_b[gi] & s_reg[3]));
  end

  // Outside RUN the slice sees a neutral logic-mode input with no carry.
  assign slice_p    = running ? p_bits      : 4'hF;
  assign slice_g    = running ? g_bits      : 4'hF;
  assign slice_m    = running ? m_reg       : 1'b1;
  assign slice_ci_n = running ? carry_n_reg : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      s_reg        <= 4'h0;
      m_reg        <= 1'b0;
      carry_n_reg  <= 1'b1;
      idx_reg      <= '0;
      aeqb_acc_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      co_n_reg     <= 1'b1;
      aeqb_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        state_reg    <= RUN;
        a_reg        <= a;
        b_reg        <= b;
        s_reg        <= s;
        m_reg        <= m;
        carry_n_reg  <= ci_n;
        idx_reg      <= '0;
        aeqb_acc_reg <= 1'b1;
        busy_reg     <= 1'b1;
        co_n_reg     <= 1'b1;
        aeqb_reg     <= 1'b0;
      end else begin
        case (state_reg)
          RUN: begin
            // The carry ripples in logic mode too; co_n simply carries no meaning then.
            carry_n_reg  <= slice_co_n;
            aeqb_acc_reg <= aeqb_acc_reg & slice_aeqb;
            if (last_nibble) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              co_n_reg  <= slice_co_n;
              aeqb_reg  <= aeqb_acc_reg & slice_aeqb;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign co_n = co_n_reg;
  assign aeqb = aeqb_reg;

endmodule
